instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Writer-side counterpart of the instruction-fetch path: receives a program image as a byte stream and writes assembled 32-bit instruction words into instruction memory.
- Holds the CPU (PC and register-write gating via cpu_hold) while loading, then releases it.
- Sits between the host/UART byte source and the instruction memory write port.

Parameters:
- DATA_WIDTH, 32, instruction word and write-address width.
- MEM_ADDR_WIDTH, 8, log2 of instruction memory depth in words; maximum image size is 2**MEM_ADDR_WIDTH words.
- BASE_ADDR, 32'h0, byte address of the first instruction word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- start  input  1  begin a load; sampled in IDLE, DONE and ERR.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  DATA_WIDTH  byte address of the word being written.
- wr_data  output  DATA_WIDTH  assembled instruction word.
- cpu_hold  output  1  CPU stalled while high.
- done  output  1  load completed successfully (level).
- error  output  1  header rejected (level).
- word_count  output  MEM_ADDR_WIDTH+1  words written so far in the current load.

Behaviour:
- Transfer occurs on a rising edge where byte_valid and byte_ready are both 1. byte_in may change only after the transfer. byte_valid may be held low indefinitely with no timeout.
- States:
  - IDLE: outputs inactive; start goes to HDR_LO, sets cpu_hold=1, clears word_count, done and error.
  - HDR_LO: byte_ready=1; the transferred byte becomes N[7:0]; go to HDR_HI.
  - HDR_HI: byte_ready=1; the transferred byte becomes N[15:8]. Then:
    - N==0 goes to DONE.
    - N>2**MEM_ADDR_WIDTH goes to ERR.
    - Otherwise go to DATA with byte index 0.
  - DATA: byte_ready=1; bytes are little-endian, so byte k lands in word bits [8k+7:8k]. The 4th byte goes to WRITE.
  - WRITE: byte_ready=0; wr_en=1 for exactly this cycle.
    - wr_addr = BASE_ADDR + 4*word_count.
    - wr_data = the assembled word.
    - word_count increments at the end of the cycle.
    - If the new count equals N, go to DONE; else go to DATA.
  - DONE: done=1, cpu_hold=0. start begins a new load (HDR_LO), clearing done.
  - ERR: error=1, cpu_hold=1, no writes. start restarts (HDR_LO), clearing error.
- Latency:
  - wr_en is asserted in the cycle after the transfer of the word's 4th byte.
  - A sustained stream costs 5 cycles per word (4 transfers plus 1 write bubble).
- wr_addr and wr_data hold their last written values when wr_en=0. They are 0 after reset.
- start while in HDR_LO, HDR_HI, DATA or WRITE is ignored.
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0, word_count=0, state=IDLE.
- Reset asserted mid-load:
  - Reset immediately aborts the load, and any partial word is discarded.
  - No wr_en is issued during reset or on the first edge after release.
  - Words already written are not undone.
- Address arithmetic is DATA_WIDTH wide and wraps modulo 2**DATA_WIDTH. word_count never exceeds 2**MEM_ADDR_WIDTH.
- byte_ready depends only on state, with no combinational path from byte_valid.

Test Plan:
- Reset, then start, then stream 02 00 13 05 A0 00 93 05 10 00 with byte_valid=1 continuously. Expect:
  - wr_en with addr 0x0, data 0x00A00513.
  - wr_en with addr 0x4, data 0x00100593.
  - done=1 and cpu_hold=0 afterwards; word_count=2.
- Header 00 00 -> DONE on the cycle after the 2nd byte transfer, with no wr_en and word_count=0.
- With MEM_ADDR_WIDTH=8, header 01 01 (N=257) -> error=1, cpu_hold=1, no wr_en. Then start followed by header 01 00 and 4 data bytes -> one write and done=1.
- With BASE_ADDR=32'h100, toggle byte_valid 1/0 randomly across a 3-word image. Expect:
  - Writes at 0x100, 0x104 and 0x108 with correct data.
  - byte_ready=0 in each WRITE cycle, and no byte lost or duplicated.
- Assert rst low after 2 data bytes of the first word. Expect:
  - All outputs are 0 immediately (asynchronous).
  - After release, start and a fresh 1-word image write only the new word at BASE_ADDR.
- Pulse start during DATA -> ignored: stream continues, and the byte index and word_count are unchanged.

Source files
------------

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader that writes 32-bit words into instruction memory
// Holds the CPU while a length-prefixed little-endian image is streamed in.
module instr_loader #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    MEM_ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  output logic                      wr_en,
  output logic [DATA_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      error,
  output logic [MEM_ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'(1) << MEM_ADDR_WIDTH;

  state_t                  state;
  state_t                  state_nxt;
  logic [15:0]             n_words;
  logic [15:0]             n_full;
  logic [1:0]              byte_idx;
  logic [23:0]             word_buf;
  logic [MEM_ADDR_WIDTH:0] wc_next;
  logic                    xfer;

  assign xfer    = byte_valid & byte_ready;
  assign wc_next = word_count + {{MEM_ADDR_WIDTH{1'b0}}, 1'b1};
  assign n_full  = {byte_in, n_words[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Decisions use byte_valid directly: every state that reads it already has byte_ready high.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) state_nxt = S_HDR_HI;
      end
      S_HDR_HI: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) begin
          if (n_full == 16'h0)                   state_nxt = S_DONE;
          else if ({16'h0, n_full} > MAX_WORDS)  state_nxt = S_ERR;
          else                                   state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en    = 1'b1;
        cpu_hold = 1'b1;
        if (32'(wc_next) == {16'h0, n_words}) state_nxt = S_DONE;
        else                                  state_nxt = S_DATA;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_HDR_LO;
      end
      S_ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) state_nxt = S_HDR_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // wr_addr/wr_data are loaded on the 4th byte so they are valid during WRITE and hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words    <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      word_count <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            word_count <= '0;
            byte_idx   <= '0;
          end
        end
        S_HDR_LO: if (xfer) n_words[7:0] <= byte_in;
        S_HDR_HI: if (xfer) n_words[15:8] <= byte_in;
        S_DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    word_buf[7:0]   <= byte_in;
              2'd1:    word_buf[15:8]  <= byte_in;
              2'd2:    word_buf[23:16] <= byte_in;
              default: begin
                wr_data <= DATA_WIDTH'({byte_in, word_buf});
                wr_addr <= BASE_ADDR + (DATA_WIDTH'(word_count) << 2);
              end
            endcase
          end
        end
        S_WRITE: word_count <= wc_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader
// Two instances (base 0x0 and 0x100) share one stimulus stream and one expected-write queue.
module tb_instr_loader;

  localparam logic [31:0] BASE0 = 32'h0;
  localparam logic [31:0] BASE1 = 32'h100;

  logic             clk;
  logic             rst;
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic [1:0]       byte_ready;
  logic [1:0]       wr_en;
  logic [1:0][31:0] wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       cpu_hold;
  logic [1:0]       done;
  logic [1:0]       error;
  logic [1:0][8:0]  word_count;

  int          checks;
  int          errors;
  int          cyc;
  logic [31:0] img[$];
  logic [31:0] exp_data[$];
  int          exp_idx[$];
  int          wr_cyc[$];
  logic [31:0] mon_data;
  int          mon_idx;

  instr_loader #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(8), .BASE_ADDR(BASE0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .cpu_hold(cpu_hold[0]), .done(done[0]), .error(error[0]), .word_count(word_count[0])
  );

  instr_loader #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(8), .BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .cpu_hold(cpu_hold[1]), .done(done[1]), .error(error[1]), .word_count(word_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next word of the image, in order, on both instances.
  always @(negedge clk) begin
    if (wr_en != 2'b00) begin
      if (exp_data.size() == 0) begin
        check("spurious_wr", {30'h0, wr_en}, 32'h0);
      end else begin
        mon_data = exp_data.pop_front();
        mon_idx  = exp_idx.pop_front();
        wr_cyc.push_back(cyc);
        for (int d = 0; d < 2; d++) begin
          check("wr_en", {31'h0, wr_en[d]}, 32'h1);
          check("wr_addr", wr_addr[d], (d == 1 ? BASE1 : BASE0) + 32'(4 * mon_idx));
          check("wr_data", wr_data[d], mon_data);
          check("ready_in_write", {31'h0, byte_ready[d]}, 32'h0);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_ready"}, {31'h0, byte_ready[d]}, 32'h0);
      check({tag, "_wr_en"}, {31'h0, wr_en[d]}, 32'h0);
      check({tag, "_addr"}, wr_addr[d], 32'h0);
      check({tag, "_data"}, wr_data[d], 32'h0);
      check({tag, "_hold"}, {31'h0, cpu_hold[d]}, 32'h0);
      check({tag, "_done"}, {31'h0, done[d]}, 32'h0);
      check({tag, "_error"}, {31'h0, error[d]}, 32'h0);
      check({tag, "_wc"}, {23'h0, word_count[d]}, 32'h0);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    byte_valid = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Entered and left 1 time unit after a rising edge; the byte transfers on the edge just before return.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready[0] && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready[0]) check("ready_timeout", {31'h0, byte_ready[0]}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic load(input int n, input bit gaps, input int poke);
    int          bi;
    logic [31:0] w;
    do_start();
    for (int d = 0; d < 2; d++) begin
      check("start_wc", {23'h0, word_count[d]}, 32'h0);
      check("start_done", {31'h0, done[d]}, 32'h0);
      check("start_error", {31'h0, error[d]}, 32'h0);
      check("start_hold", {31'h0, cpu_hold[d]}, 32'h1);
    end
    w = 32'(n);
    send_byte(w[7:0], gaps);
    send_byte(w[15:8], gaps);
    if (n == 0 || n > 256) begin
      byte_valid = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("hdr_done", {31'h0, done[d]}, (n == 0) ? 32'h1 : 32'h0);
        check("hdr_error", {31'h0, error[d]}, (n == 0) ? 32'h0 : 32'h1);
        check("hdr_hold", {31'h0, cpu_hold[d]}, (n == 0) ? 32'h0 : 32'h1);
        check("hdr_wc", {23'h0, word_count[d]}, 32'h0);
      end
      repeat (3) @(posedge clk);
      #1;
    end else begin
      bi = 0;
      for (int i = 0; i < n; i++) begin
        exp_data.push_back(img[i]);
        exp_idx.push_back(i);
        w = img[i];
        for (int k = 0; k < 4; k++) begin
          if (bi == poke) begin
            byte_valid = 1'b0;
            start      = 1'b1;
            @(posedge clk); #1;
            start      = 1'b0;
            for (int d = 0; d < 2; d++) check("poke_wc", {23'h0, word_count[d]}, 32'(i));
          end
          send_byte(w[8*k +: 8], gaps);
          bi++;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("wr_latency", {31'h0, wr_en[d]}, 32'h1);
        @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("end_done", {31'h0, done[d]}, 32'h1);
        check("end_hold", {31'h0, cpu_hold[d]}, 32'h0);
        check("end_error", {31'h0, error[d]}, 32'h0);
        check("end_wc", {23'h0, word_count[d]}, 32'(n));
      end
      check("all_words_written", 32'(exp_data.size()), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    img = '{32'h00A00513, 32'h00100593};
    wr_cyc.delete();
    load(2, 1'b0, -1);
    check("word_period", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);

    load(0, 1'b0, -1);

    load(257, 1'b0, -1);
    rand_img(1);
    load(1, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      rand_img(3 + t % 3);
      load(img.size(), 1'b1, -1);
    end

    load($urandom_range(258, 65535), 1'b1, -1);

    rand_img(3);
    load(3, 1'b1, 2);

    rand_img(256);
    load(256, 1'b0, -1);

    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte($urandom_range(0, 255), 1'b0);
    send_byte($urandom_range(0, 255), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    byte_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rand_img(1);
    load(1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
